// File: rtl/rom_msg_pkg.sv
// Shared definitions for the ROM message streamer and the 16x8 character ROM
// it reads from: address/data widths, the stored message length, the NUL
// terminator value and the streamer state encoding.
`timescale 1ns/1ps
package rom_msg_pkg;

    localparam int ROM_ADDR_W  = 4;
    localparam int ROM_DATA_W  = 8;
    localparam int DEF_MSG_LEN = 11;

    localparam logic [7:0] NUL_CHAR = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/rom_msg_streamer.sv
// Walks the character ROM from address 0 and streams each byte to a serial
// transmitter over a valid/ready handshake. A NUL byte ends the message
// early; repeat_en at the last byte wraps back to address 0; an optional
// idle gap follows every accepted byte; abort returns to IDLE at once.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a message (IDLE only)
//   repeat_en           at the last byte: 1 = wrap to address 0 and continue
//   abort               drop the current message, no done pulse
//   rom_addr / rom_data combinational ROM lookup
//   tx_data / tx_valid  registered character toward the transmitter
//   tx_ready            transmitter accepts tx_data this cycle
//   busy                high whenever not IDLE
//   done                one-cycle pulse on normal completion
//   char_idx            address of the byte presented or being fetched
`timescale 1ns/1ps
module rom_msg_streamer
    import rom_msg_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int MSG_LEN    = DEF_MSG_LEN,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              repeat_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] char_idx
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    localparam bit                HAS_GAP   = (GAP_CYCLES > 0);
    // The counter is preloaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [7:0]        GAP_LOAD  = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          gap_q, gap_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                handshake_s;
    logic                at_last_s;
    logic [ADDR_W-1:0]   next_addr_s;
    state_e              cont_state_s;

    // Next-state, address, gap counter and output computation.
    always_comb begin
        handshake_s  = tx_valid_q & tx_ready;
        at_last_s    = (addr_q == LAST_ADDR);
        // Wrap is explicit so a MSG_LEN below 2^ADDR_W never overflows past it.
        next_addr_s  = at_last_s ? {ADDR_W{1'b0}} : (addr_q + ADDR_W'(1));
        cont_state_s = HAS_GAP ? ST_GAP : ST_LOAD;

        state_d    = state_q;
        addr_d     = addr_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_LOAD;
                    addr_d  = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    gap_d      = 8'd0;
                end else begin
                    tx_data_d = rom_data;
                    if (rom_data == DATA_W'(NUL_CHAR)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_SEND;
                        tx_valid_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // abort wins even over a handshake; the byte is still consumed.
                if (abort) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    gap_d      = 8'd0;
                end else if (handshake_s) begin
                    tx_valid_d = 1'b0;
                    if (at_last_s && !repeat_en) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = next_addr_s;
                        gap_d   = GAP_LOAD;
                        state_d = cont_state_s;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    gap_d   = 8'd0;
                end else if (gap_q == 8'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                gap_d      = 8'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            gap_q      <= 8'd0;
            tx_data_q  <= {DATA_W{1'b0}};
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign char_idx = addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
